// File: rtl/riscv_mem_pkg.sv
// rtl/riscv_mem_pkg.sv - shared widths and response type for the instruction memory model
`ifndef RISCV_ADDR_WIDTH
`define RISCV_ADDR_WIDTH 32
`endif
`ifndef RISCV_WORD_WIDTH
`define RISCV_WORD_WIDTH 32
`endif

package riscv_mem_pkg;

   localparam int ADDR_WIDTH = `RISCV_ADDR_WIDTH;
   localparam int WORD_WIDTH = `RISCV_WORD_WIDTH;

   typedef struct packed {
      logic                  valid;
      logic [WORD_WIDTH-1:0] data;
   } mem_resp_t;

endpackage

// File: rtl/instr_mem_responder_if.sv
// rtl/instr_mem_responder_if.sv - fetch-side req/gnt/rvalid bus
interface instr_mem_responder_if #(
   parameter int ADDR_WIDTH = `RISCV_ADDR_WIDTH,
   parameter int DATA_WIDTH = `RISCV_WORD_WIDTH
);

   logic                  req;
   logic [ADDR_WIDTH-1:0] addr;
   logic                  gnt;
   logic                  rvalid;
   logic [DATA_WIDTH-1:0] rdata;

   modport master (
      output req,
      output addr,
      input  gnt,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output gnt,
      output rvalid,
      output rdata
   );

endinterface

// File: rtl/resp_delay_line.sv
// rtl/resp_delay_line.sv - fixed-length shift register of {valid, data} responses
module resp_delay_line
   import riscv_mem_pkg::*;
#(
   parameter int STAGES = 1
) (
   input  logic      clk,
   input  logic      rst_n,
   input  mem_resp_t head,
   output mem_resp_t tail
);

   mem_resp_t stage [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) begin
            stage[i] <= '0;
         end
      end else begin
         stage[0] <= head;
         for (int i = 1; i < STAGES; i++) begin
            stage[i] <= stage[i-1];
         end
      end
   end

   assign tail = stage[STAGES-1];

endmodule

// File: rtl/instr_mem_responder.sv
// rtl/instr_mem_responder.sv - instruction memory responder: word array, grant logic,
// outstanding cap, stall injector and in-order fixed-latency returns
module instr_mem_responder
   import riscv_mem_pkg::*;
#(
   parameter int ADDR_WIDTH      = `RISCV_ADDR_WIDTH,
   parameter int DATA_WIDTH      = `RISCV_WORD_WIDTH,
   parameter int DEPTH           = 1024,
   parameter int LATENCY         = 1,
   parameter int MAX_OUTSTANDING = 1,
   parameter int STALL_PERIOD    = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   instr_mem_responder_if.slave  bus,
   input  logic                  load_we,
   input  logic [ADDR_WIDTH-1:0] load_addr,
   input  logic [DATA_WIDTH-1:0] load_wdata
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [IDX_W-1:0]      fetch_idx;
   logic [IDX_W-1:0]      load_idx;
   logic                  gnt;
   logic                  stall_now;
   logic [CNT_W-1:0]      outstanding;
   logic [CNT_W-1:0]      in_flight;
   logic [DATA_WIDTH-1:0] rdata_hold;
   mem_resp_t             head;
   mem_resp_t             tail;

   // Upper address bits only alias onto the array.
   assign fetch_idx = bus.addr[IDX_W-1:0];
   assign load_idx  = load_addr[IDX_W-1:0];
   wire unused_addr_bits = ^{1'b0, bus.addr[ADDR_WIDTH-1:IDX_W], load_addr[ADDR_WIDTH-1:IDX_W]};

   always_ff @(posedge clk) begin
      if (load_we) begin
         mem[load_idx] <= load_wdata;
      end
   end

   generate
      if (STALL_PERIOD > 0) begin : gen_stall
         localparam int SW = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;
         logic [SW-1:0] stall_cnt;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               stall_cnt <= '0;
            end else if (stall_cnt == SW'(STALL_PERIOD - 1)) begin
               stall_cnt <= '0;
            end else begin
               stall_cnt <= stall_cnt + SW'(1);
            end
         end

         assign stall_now = (stall_cnt == SW'(STALL_PERIOD - 1));
      end else begin : gen_no_stall
         assign stall_now = 1'b0;
      end
   endgenerate

   // A return in this cycle frees its slot for a same-cycle grant.
   assign in_flight = outstanding - CNT_W'(tail.valid);
   assign gnt       = bus.req && !stall_now && (in_flight < CNT_W'(MAX_OUTSTANDING));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding <= '0;
      end else if (gnt && !tail.valid) begin
         outstanding <= outstanding + CNT_W'(1);
      end else if (!gnt && tail.valid) begin
         outstanding <= outstanding - CNT_W'(1);
      end
   end

   always_comb begin
      head       = '0;
      head.valid = gnt;
      head.data  = mem[fetch_idx];
   end

   resp_delay_line #(
      .STAGES (LATENCY)
   ) u_delay (
      .clk   (clk),
      .rst_n (rst_n),
      .head  (head),
      .tail  (tail)
   );

   // Delay-line data is meaningless without valid, so rdata replays the last return.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_hold <= '0;
      end else if (tail.valid) begin
         rdata_hold <= tail.data;
      end
   end

   assign bus.gnt    = gnt;
   assign bus.rvalid = tail.valid;
   assign bus.rdata  = tail.valid ? tail.data : rdata_hold;

endmodule

// File: tb/tb_instr_mem_responder.sv
// tb/tb_instr_mem_responder.sv - directed bench for instr_mem_responder across four configurations
module tb_instr_mem_responder;

   logic        clk;
   logic        rst_n;
   logic        load_we;
   logic [31:0] load_addr;
   logic [31:0] load_wdata;
   int          checks = 0;
   int          failures = 0;
   int          since_rst = 0;
   logic [31:0] model [8];

   instr_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_a ();
   instr_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_b ();
   instr_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_c ();
   instr_mem_responder_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus_d ();

   instr_mem_responder #(.DEPTH(1024), .LATENCY(1), .MAX_OUTSTANDING(1), .STALL_PERIOD(0)) dut_a (
      .clk(clk), .rst_n(rst_n), .bus(bus_a),
      .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata));
   instr_mem_responder #(.DEPTH(1024), .LATENCY(3), .MAX_OUTSTANDING(1), .STALL_PERIOD(0)) dut_b (
      .clk(clk), .rst_n(rst_n), .bus(bus_b),
      .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata));
   instr_mem_responder #(.DEPTH(1024), .LATENCY(1), .MAX_OUTSTANDING(1), .STALL_PERIOD(4)) dut_c (
      .clk(clk), .rst_n(rst_n), .bus(bus_c),
      .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata));
   instr_mem_responder #(.DEPTH(1024), .LATENCY(2), .MAX_OUTSTANDING(2), .STALL_PERIOD(0)) dut_d (
      .clk(clk), .rst_n(rst_n), .bus(bus_d),
      .load_we(load_we), .load_addr(load_addr), .load_wdata(load_wdata));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Mirrors the stall counter phase: cycles elapsed since reset release.
   always @(posedge clk) begin
      if (!rst_n) since_rst <= 0;
      else        since_rst <= since_rst + 1;
   end

   task automatic test_reset();
      @(negedge clk); #1;
      checks++; if (bus_a.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid_a got=%b exp=0", bus_a.rvalid); end
      checks++; if (bus_a.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata_a got=%h exp=0", bus_a.rdata); end
      checks++; if (bus_b.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid_b got=%b exp=0", bus_b.rvalid); end
      checks++; if (bus_c.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid_c got=%b exp=0", bus_c.rvalid); end
      checks++; if (bus_d.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid_d got=%b exp=0", bus_d.rvalid); end
      checks++; if (bus_d.rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata_d got=%h exp=0", bus_d.rdata); end
      checks++; if (bus_a.gnt !== 1'b0) begin failures++; $display("FAIL reset_gnt_idle got=%b exp=0", bus_a.gnt); end
   endtask

   task automatic preload();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         load_we    = 1'b1;
         load_addr  = 32'(i);
         load_wdata = model[i];
      end
      @(negedge clk);
      load_we = 1'b0;
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus_a.req  = (i < 4);
         bus_a.addr = 32'(i);
         #1;
         checks++; if (bus_a.gnt !== (i < 4)) begin failures++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", i, bus_a.gnt, (i < 4)); end
         checks++; if (bus_a.rvalid !== (i > 0)) begin failures++; $display("FAIL b2b_rvalid cyc=%0d got=%b exp=%b", i, bus_a.rvalid, (i > 0)); end
         if (i > 0) begin
            checks++; if (bus_a.rdata !== model[i-1]) begin failures++; $display("FAIL b2b_rdata cyc=%0d got=%h exp=%h", i, bus_a.rdata, model[i-1]); end
         end
      end
      @(negedge clk); #1;
      checks++; if (bus_a.rvalid !== 1'b0) begin failures++; $display("FAIL b2b_rvalid_idle got=%b exp=0", bus_a.rvalid); end
      checks++; if (bus_a.rdata !== 32'h44) begin failures++; $display("FAIL b2b_rdata_hold got=%h exp=44", bus_a.rdata); end
   endtask

   task automatic test_latency3();
      for (int i = 0; i < 13; i++) begin
         @(negedge clk);
         bus_b.req  = (i < 10);
         bus_b.addr = 32'((i + 2) / 3);
         #1;
         checks++; if (bus_b.gnt !== ((i < 10) && (i % 3 == 0))) begin failures++; $display("FAIL lat3_gnt cyc=%0d got=%b exp=%b", i, bus_b.gnt, ((i < 10) && (i % 3 == 0))); end
         checks++; if (bus_b.rvalid !== ((i > 0) && (i % 3 == 0))) begin failures++; $display("FAIL lat3_rvalid cyc=%0d got=%b exp=%b", i, bus_b.rvalid, ((i > 0) && (i % 3 == 0))); end
         if ((i > 0) && (i % 3 == 0)) begin
            checks++; if (bus_b.rdata !== model[i/3 - 1]) begin failures++; $display("FAIL lat3_rdata cyc=%0d got=%h exp=%h", i, bus_b.rdata, model[i/3 - 1]); end
         end
      end
      bus_b.req = 1'b0;
   endtask

   task automatic test_stall();
      logic exp_g;
      logic prev_g = 1'b0;
      int   prev_addr = 0;
      int   n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         bus_c.req  = 1'b1;
         bus_c.addr = 32'(n % 8);
         #1;
         exp_g = ((since_rst % 4) != 3);
         checks++; if (bus_c.gnt !== exp_g) begin failures++; $display("FAIL stall_gnt cyc=%0d got=%b exp=%b", i, bus_c.gnt, exp_g); end
         checks++; if (bus_c.rvalid !== prev_g) begin failures++; $display("FAIL stall_rvalid cyc=%0d got=%b exp=%b", i, bus_c.rvalid, prev_g); end
         if (prev_g) begin
            checks++; if (bus_c.rdata !== model[prev_addr]) begin failures++; $display("FAIL stall_rdata cyc=%0d got=%h exp=%h", i, bus_c.rdata, model[prev_addr]); end
         end
         prev_g    = exp_g;
         prev_addr = n % 8;
         if (exp_g) n++;
      end
      @(negedge clk);
      bus_c.req = 1'b0;
   endtask

   task automatic test_loader_collision();
      @(negedge clk);
      bus_a.req  = 1'b1;
      bus_a.addr = 32'd5;
      load_we    = 1'b1;
      load_addr  = 32'd5;
      load_wdata = 32'hDEAD;
      #1;
      checks++; if (bus_a.gnt !== 1'b1) begin failures++; $display("FAIL load_gnt got=%b exp=1", bus_a.gnt); end
      @(negedge clk);
      load_we = 1'b0;
      #1;
      checks++; if (bus_a.rvalid !== 1'b1) begin failures++; $display("FAIL load_old_rvalid got=%b exp=1", bus_a.rvalid); end
      checks++; if (bus_a.rdata !== 32'hBEEF) begin failures++; $display("FAIL load_old_rdata got=%h exp=BEEF", bus_a.rdata); end
      @(negedge clk);
      bus_a.req = 1'b0;
      #1;
      checks++; if (bus_a.rdata !== 32'hDEAD) begin failures++; $display("FAIL load_new_rdata got=%h exp=DEAD", bus_a.rdata); end
      model[5] = 32'hDEAD;
   endtask

   task automatic test_alias();
      @(negedge clk);
      bus_a.req  = 1'b1;
      bus_a.addr = 32'h400;
      #1;
      checks++; if (bus_a.gnt !== 1'b1) begin failures++; $display("FAIL alias_gnt got=%b exp=1", bus_a.gnt); end
      @(negedge clk);
      bus_a.addr = 32'h407;
      #1;
      checks++; if (bus_a.rdata !== model[0]) begin failures++; $display("FAIL alias_400 got=%h exp=%h", bus_a.rdata, model[0]); end
      @(negedge clk);
      bus_a.req = 1'b0;
      #1;
      checks++; if (bus_a.rdata !== model[7]) begin failures++; $display("FAIL alias_407 got=%h exp=%h", bus_a.rdata, model[7]); end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      bus_d.req  = 1'b1;
      bus_d.addr = 32'd0;
      #1;
      checks++; if (bus_d.gnt !== 1'b1) begin failures++; $display("FAIL rst_gnt0 got=%b exp=1", bus_d.gnt); end
      @(negedge clk);
      bus_d.addr = 32'd1;
      #1;
      checks++; if (bus_d.gnt !== 1'b1) begin failures++; $display("FAIL rst_gnt1 got=%b exp=1", bus_d.gnt); end
      @(negedge clk);
      bus_d.req = 1'b0;
      #1;
      checks++; if (bus_d.rvalid !== 1'b1) begin failures++; $display("FAIL rst_pre_rvalid got=%b exp=1", bus_d.rvalid); end
      checks++; if (bus_d.rdata !== model[0]) begin failures++; $display("FAIL rst_pre_rdata got=%h exp=%h", bus_d.rdata, model[0]); end
      rst_n = 1'b0;
      #1;
      checks++; if (bus_d.rvalid !== 1'b0) begin failures++; $display("FAIL rst_async_rvalid got=%b exp=0", bus_d.rvalid); end
      checks++; if (bus_d.rdata !== 32'h0) begin failures++; $display("FAIL rst_async_rdata got=%h exp=0", bus_d.rdata); end
      @(negedge clk);
      @(negedge clk);
      rst_n      = 1'b1;
      bus_d.req  = 1'b1;
      bus_d.addr = 32'd2;
      #1;
      checks++; if (bus_d.gnt !== 1'b1) begin failures++; $display("FAIL rst_first_gnt got=%b exp=1", bus_d.gnt); end
      checks++; if (bus_d.rvalid !== 1'b0) begin failures++; $display("FAIL rst_stale0 got=%b exp=0", bus_d.rvalid); end
      @(negedge clk);
      bus_d.req = 1'b0;
      #1;
      checks++; if (bus_d.rvalid !== 1'b0) begin failures++; $display("FAIL rst_stale1 got=%b exp=0", bus_d.rvalid); end
      @(negedge clk); #1;
      checks++; if (bus_d.rvalid !== 1'b1) begin failures++; $display("FAIL rst_post_rvalid got=%b exp=1", bus_d.rvalid); end
      checks++; if (bus_d.rdata !== model[2]) begin failures++; $display("FAIL rst_post_rdata got=%h exp=%h", bus_d.rdata, model[2]); end
      @(negedge clk); #1;
      checks++; if (bus_d.rvalid !== 1'b0) begin failures++; $display("FAIL rst_post_idle got=%b exp=0", bus_d.rvalid); end
   endtask

   initial begin
      model[0] = 32'h11;   model[1] = 32'h22;   model[2] = 32'h33;   model[3] = 32'h44;
      model[4] = 32'h55;   model[5] = 32'hBEEF; model[6] = 32'h77;   model[7] = 32'h88;
      rst_n      = 1'b0;
      load_we    = 1'b0;
      load_addr  = '0;
      load_wdata = '0;
      bus_a.req = 1'b0; bus_a.addr = '0;
      bus_b.req = 1'b0; bus_b.addr = '0;
      bus_c.req = 1'b0; bus_c.addr = '0;
      bus_d.req = 1'b0; bus_d.addr = '0;

      test_reset();
      @(negedge clk);
      rst_n = 1'b1;
      preload();
      test_back_to_back();
      test_latency3();
      test_stall();
      test_loader_collision();
      test_alias();
      test_reset_mid();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/instr_mem_responder.md
Name: instr_mem_responder

Overview:
- Responder end of the req/gnt/rvalid instruction-fetch protocol driven by the fetch stage.
- Accepts word-addressed fetch requests, grants them subject to an outstanding-request cap and an optional stall injector, and returns read data in order with rvalid a fixed number of cycles after grant.
- Backed by a word array with a loader write port; serves as the instruction memory model for core bring-up and fetch-stage verification.

Parameters:
ADDR_WIDTH, `RISCV_ADDR_WIDTH, request address width
DATA_WIDTH, `RISCV_WORD_WIDTH, instruction word width
DEPTH, 1024, words in array (power of two)
LATENCY, 1, cycles from grant cycle to rvalid (>= 1)
MAX_OUTSTANDING, 1, granted-but-not-returned cap (1..LATENCY)
STALL_PERIOD, 0, 0 = never stall; N > 0 = gnt forced low one cycle in every N

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous reset, active low
instr_req_i  in  1  fetch request
instr_addr_i  in  ADDR_WIDTH  word address
instr_gnt_o  out  1  request accepted this cycle
instr_rvalid_o  out  1  read data valid
instr_rdata_o  out  DATA_WIDTH  read data
load_we_i  in  1  loader write enable
load_addr_i  in  ADDR_WIDTH  loader word address
load_wdata_i  in  DATA_WIDTH  loader write data

Behaviour:
- Clock is clk. Reset rst_n is asynchronous and active-low. This is already decided.
- Reset values: instr_rvalid_o = 0, instr_rdata_o = 0, outstanding count = 0, stall counter = 0, all delay stages invalid. Array contents are not reset.
- Indexing: the index is addr[log2(DEPTH)-1:0]. Upper bits are ignored, so addresses alias and wrap, with no error.
- Grant is combinational in the request cycle:
  - gnt = req && !stall_now && (outstanding - rvalid_now) < MAX_OUTSTANDING.
  - A return in the same cycle frees its slot. At LATENCY = 1, MAX_OUTSTANDING = 1 this sustains one grant per cycle.
- gnt is 0 whenever req is 0.
- On a grant in cycle t:
  - array[index] is read in cycle t and pushed into a LATENCY-stage delay line.
  - instr_rvalid_o = 1 with that data in cycle t+LATENCY, for exactly one cycle.
  - Returns are in grant order.
- rvalid has no back-pressure; the initiator must accept it. instr_rdata_o holds its last value when rvalid = 0.
- outstanding: +1 on grant, -1 on rvalid, unchanged when both occur. It never exceeds MAX_OUTSTANDING and never underflows.
- Stall injector (STALL_PERIOD = N > 0):
  - Free-running counter 0..N-1, wraps.
  - stall_now = (counter == N-1), independent of req.
  - A request pending during a stall stays pending and is granted on a later cycle. The address must be held by the initiator.
- Loader writes:
  - load_we_i writes array[load index] at the clock edge.
  - Read and write to the same index in one cycle: the read returns the old data.
  - Loader writes never affect gnt.
- Request dropped (req falls) after grant: the return still occurs at t+LATENCY.
- Reset mid-operation: all in-flight responses are discarded, and rvalid is 0 from reset assertion onward. After release, the first grant is possible in the first cycle.
- No FSM beyond the counters. The delay line is a shift register of {valid, data} stages.

Decomposition:
- Shared package `riscv_mem_pkg`: ADDR/WORD width constants (aliases of the `RISCV_* macros), and a typedef `mem_resp_t` = {logic valid; logic [WORD-1:0] data}.
- One sub-module, `resp_delay_line`:
  - Parameter STAGES; input mem_resp_t; output mem_resp_t after STAGES cycles.
  - Async active-low reset clears the valid bits.
- Top level holds the array, grant logic, outstanding counter and stall counter.

Test Plan:
- Preload array[0..3] = 0x11,0x22,0x33,0x44; LATENCY = 1, MAX = 1; req held with addr 0,1,2,3 -> gnt every cycle; rvalid in cycles t+1..t+4 with data 0x11,0x22,0x33,0x44.
- LATENCY = 3, MAX = 1; req held -> gnt once every 3 cycles; rvalid 3 cycles after each gnt; outstanding never exceeds 1.
- STALL_PERIOD = 4, req held -> gnt low exactly on every 4th cycle; 3 returns per 4 cycles; data order preserved.
- Loader writes array[5] = 0xDEAD in the same cycle as a fetch granted at addr 5 (old value 0xBEEF) -> returns 0xBEEF; refetch -> 0xDEAD.
- DEPTH = 1024, addr 0x400 -> returns array[0].
- LATENCY = 2, two grants in flight, rst_n pulsed low -> rvalid 0 immediately; no stale returns after release; the next fetch is granted in the first cycle.
